// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control for the 16-bit byte-addressed instruction memory.
// Optional fetch range check enabled by defining PC_BOUNDS_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        pc_wre,
  input  logic [1:0]  pc_src,
  input  logic [15:0] imm,
  input  logic [15:0] jump_addr,
  input  logic [15:0] instr,
  output logic [15:0] address,
  output logic        ins_mem_rw,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  state_t      state, state_n;
  logic [15:0] npc, address_n;
  logic [15:0] imm_x2;
  logic        out_of_range;
  logic        unused_bits;

  assign pc_plus2 = address + 16'd2;
  assign imm_x2   = {imm[14:0], 1'b0};

  // Bits that take no part in fetch decisions.
  assign unused_bits = ^{instr[11:0], jump_addr[0]};

  always_comb begin
    npc = pc_plus2;
    case (pc_src)
      2'b00:   npc = pc_plus2;
      2'b01:   npc = pc_plus2 + imm_x2;
      2'b10:   npc = {jump_addr[15:1], 1'b0};
      default: npc = address;
    endcase
  end

`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [16:0] PC_LIMIT = 17'(MEM_BYTES - 2);

  // Stall re-fetches the current, already validated PC, so it is never checked.
  assign out_of_range = (pc_src != 2'b11) && ({1'b0, npc} > PC_LIMIT);
  assign fault        = (state == FAULT);
`else
  logic unused_cfg;

  assign unused_cfg   = ^32'(MEM_BYTES);
  assign out_of_range = 1'b0;
  assign fault        = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    address_n = address;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (instr[15:12] == 4'hF) begin
          state_n = HALT;
        end else if (pc_wre && out_of_range) begin
          state_n = FAULT;
        end else if (pc_wre) begin
          address_n = npc;
        end
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= BOOT;
      address <= {PC_RESET[15:1], 1'b0};
    end else begin
      state   <= state_n;
      address <= address_n;
    end
  end

  assign ins_mem_rw = (state == RUN);
  assign halted     = (state == HALT);

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Program-counter and fetch-control stage directly upstream of the byte-addressed 16-bit instruction memory.
- Holds the PC and drives the fetch address and memory read-enable.
- Selects the next PC from the sequential, branch, jump or stall path.
- Stops fetching on the halt opcode and on out-of-range fetches when bounds checking is compiled in.

## Interface
- `PC_RESET`, default 16'h0000: PC value loaded on reset; bit 0 must be 0.
- `MEM_BYTES`, default 128: instruction memory size in bytes; used only by the bounds check.
- `CLK` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-low reset.
- `pc_wre` in 1: PC write enable from control; 0 holds the PC.
- `pc_src` in 2: next-PC select.
  - 00 = sequential
  - 01 = branch
  - 10 = jump
  - 11 = stall
- `imm` in 16: sign-extended branch offset, counted in instructions.
- `jump_addr` in 16: absolute jump target in bytes.
- `instr` in 16: instruction word returned by instruction memory for the current `address`.
- `address` out 16: registered fetch byte address (the PC).
- `ins_mem_rw` out 1: instruction memory read enable.
- `pc_plus2` out 16: combinational `address + 2`, for link and branch use.
- `halted` out 1: high while in HALT.
- `fault` out 1: high while in FAULT; tied 0 when `PC_BOUNDS_CHECK_EN` is not defined.

## Operation
- **Reset values:** while `Reset` = 0:
  - `address` = `PC_RESET`, state = BOOT.
  - `ins_mem_rw` = 0, `halted` = 0, `fault` = 0.
- **Next-PC value `npc`** (all arithmetic 16-bit, wrapping modulo 2^16):
  - 00 → `address + 2`.
  - 01 → `address + 2 + (imm << 1)`; the shifted-out MSB of `imm` is discarded.
  - 10 → `{jump_addr[15:1], 1'b0}`; bit 0 is forced to 0.
  - 11 → `address`.
- **State BOOT:** lasts exactly one cycle after `Reset` rises.
  - PC is held and `ins_mem_rw` = 0.
  - Next state is RUN.
- **State RUN:** `ins_mem_rw` = 1.
  - If `instr[15:12]` == 4'hF, next state is HALT and the PC is held. This applies regardless of `pc_wre` and `pc_src`.
  - Else, if bounds checking is enabled, `pc_wre` = 1 and `npc > MEM_BYTES-2`: next state is FAULT and the PC is held.
  - Else, if `pc_wre` = 1: `address` ← `npc`.
  - Else: PC is held.
- **State HALT:** sticky until reset. `halted` = 1, `ins_mem_rw` = 0, PC frozen.
- **State FAULT:** sticky until reset. `fault` = 1, `ins_mem_rw` = 0, PC frozen at the last valid address.
- **Invariant:** `address[0]` is always 0.
- **Priority on simultaneous events:** reset > halt opcode > bounds fault > `pc_wre`/`pc_src`.
- **Reset mid-operation:** asynchronous entry to BOOT from any state. Outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- `address`, `halted`, `fault` and `ins_mem_rw` are registered and change only on the `CLK` rising edge, or asynchronously on reset assertion.
- Instruction memory is combinational: `instr` corresponding to `address` is valid in the same cycle and is sampled at the next rising edge.
- First valid fetch: the cycle after BOOT, i.e. 1 cycle of latency after `Reset` deasserts.
- Branch or jump taken: the target is on `address` 1 cycle after the edge at which `pc_src` and `pc_wre` are sampled. There are no delay slots.
- HALT/FAULT entry: `halted`/`fault` rise at the same edge that would have updated the PC.
- `pc_plus2` is purely combinational from `address`.

## Configuration
- Macro `PC_BOUNDS_CHECK_EN`.
- **Defined:**
  - Any PC update whose `npc` exceeds `MEM_BYTES-2` enters FAULT; the stall path (11) never faults.
  - This covers sequential, branch (including wrap-around to a high address) and jump targets.
- **Undefined:**
  - No range check; the PC wraps freely modulo 2^16.
  - The FAULT state is unreachable and `fault` is constant 0.

## Test plan
- **Reset and boot:**
  - Stimulus: `Reset` low for 3 cycles, then high, with `instr` = 16'h0000.
  - Required: `address` = 0 and `ins_mem_rw` = 0 during the BOOT cycle; `ins_mem_rw` = 1 after; `address` = 2 after the next edge with `pc_wre` = 1 and `pc_src` = 00.
- **Branch and jump:**
  - Stimulus: at `address` = 16'h0010, `pc_src` = 01 with `imm` = 16'hFFFC (−4).
  - Required: `address` = 16'h000A. Then `pc_src` = 10 with `jump_addr` = 16'h0031 → `address` = 16'h0030.
- **Stall and hold:**
  - Stimulus: `pc_src` = 11 for 4 cycles, then `pc_wre` = 0 with `pc_src` = 00 for 2 cycles.
  - Required: `address` unchanged throughout; `pc_plus2` = `address + 2`.
- **Halt:**
  - Stimulus: `instr` = 16'hF000 at `address` = 16'h0008 with `pc_wre` = 1.
  - Required: next edge gives `halted` = 1, `ins_mem_rw` = 0 and `address` stays 16'h0008 for 10 cycles. Asserting `Reset` low mid-HALT clears `halted` immediately.
- **Bounds (macro defined):**
  - Stimulus: at `address` = 16'h007E, `pc_src` = 00 and `pc_wre` = 1.
  - Required: `fault` = 1 and `address` = 16'h007E. A jump to 16'h0100 from RUN also faults.
  - With the macro undefined, the same stimulus gives `address` = 16'h0080 and `fault` = 0.
- **Wrap:**
  - Stimulus: macro undefined, `address` = 16'hFFFE, `pc_src` = 00.
  - Required: `address` = 16'h0000.
